// File: rtl/cdb_arb_if.sv
// Signal bundle between the functional units / branch unit and the CDB arbiter.
// Field widths come from PRF_IDX_W, ROB_IDX_W and BR_MASK_W (defaults below).
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif

interface cdb_arb_if #(
    parameter int unsigned N_FU = 4
);
    logic [N_FU-1:0]              fu_done_i;
    logic [N_FU*`PRF_IDX_W-1:0]   fu_tag_i;
    logic [N_FU*`ROB_IDX_W-1:0]   fu_rob_idx_i;
    logic [N_FU*`BR_MASK_W-1:0]   fu_br_mask_i;
    logic [N_FU-1:0]              fu_full_o;
    logic                         br_pred_correct_i;
    logic                         br_recovery_i;
    logic [`BR_MASK_W-1:0]        br_tag_fix_i;
    logic                         cdb_vld_o;
    logic [`PRF_IDX_W-1:0]        cdb_tag_o;
    logic [`ROB_IDX_W-1:0]        cdb_rob_idx_o;

    modport master (
        output fu_done_i, fu_tag_i, fu_rob_idx_i, fu_br_mask_i,
        output br_pred_correct_i, br_recovery_i, br_tag_fix_i,
        input  fu_full_o, cdb_vld_o, cdb_tag_o, cdb_rob_idx_o
    );

    modport slave (
        input  fu_done_i, fu_tag_i, fu_rob_idx_i, fu_br_mask_i,
        input  br_pred_correct_i, br_recovery_i, br_tag_fix_i,
        output fu_full_o, cdb_vld_o, cdb_tag_o, cdb_rob_idx_o
    );
endinterface

// File: rtl/cdb_arb.sv
// Common Data Bus arbiter: per-FU completion queues, round-robin pick, branch squash/clear.
// Optional CDB_ARB_DEBUG_EN adds per-queue count and broadcast counter outputs.
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif

module cdb_arb #(
    parameter int unsigned N_FU    = 4,
    parameter int unsigned Q_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    cdb_arb_if.slave   bus
`ifdef CDB_ARB_DEBUG_EN
    ,
    output logic [N_FU*3-1:0] dbg_q_cnt_o,
    output logic [31:0]       dbg_bcast_cnt_o
`endif
);
    localparam int unsigned TW = `PRF_IDX_W;
    localparam int unsigned RW = `ROB_IDX_W;
    localparam int unsigned MW = `BR_MASK_W;
    localparam int unsigned CW = $clog2(Q_DEPTH + 1);
    localparam int unsigned PW = $clog2(N_FU);

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [RW-1:0] rob;
        logic [MW-1:0] mask;
    } entry_t;

    entry_t        q     [N_FU][Q_DEPTH];
    entry_t        q_nxt [N_FU][Q_DEPTH];
    logic [CW-1:0] cnt     [N_FU];
    logic [CW-1:0] cnt_nxt [N_FU];
    logic [PW-1:0] rr_ptr, rr_nxt;
    logic [N_FU-1:0] cand, full;
    logic          win_vld;
    logic [PW-1:0] win_idx;
    logic          recov, clr_en;
    logic [MW-1:0] fix;

    function automatic logic is_kill(input logic rec, input logic [MW-1:0] m, input logic [MW-1:0] f);
        return rec && ((m & f) != '0);
    endfunction

    assign recov  = bus.br_recovery_i;
    assign fix    = bus.br_tag_fix_i;
    assign clr_en = bus.br_pred_correct_i && !bus.br_recovery_i;

    always_comb begin
        for (int unsigned i = 0; i < N_FU; i++) begin
            full[i] = (cnt[i] == CW'(Q_DEPTH));
            cand[i] = (cnt[i] != '0) && !is_kill(recov, q[i][0].mask, fix);
        end
    end

    always_comb begin
        int unsigned idx;
        idx     = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int unsigned k = 0; k < N_FU; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= N_FU) idx = idx - N_FU;
            if (!win_vld && cand[idx]) begin
                win_vld = 1'b1;
                win_idx = PW'(idx);
            end
        end
        if (!win_vld)                      rr_nxt = rr_ptr;
        else if (32'(win_idx) == N_FU - 1) rr_nxt = '0;
        else                               rr_nxt = win_idx + PW'(1);
    end

    always_comb begin
        bus.fu_full_o     = full;
        bus.cdb_vld_o     = win_vld;
        bus.cdb_tag_o     = '0;
        bus.cdb_rob_idx_o = '0;
        if (win_vld) begin
            bus.cdb_tag_o     = q[win_idx][0].tag;
            bus.cdb_rob_idx_o = q[win_idx][0].rob;
        end
    end

    // Survivors (not killed, not the dequeued head) compact toward slot 0, then the accepted
    // incoming result lands right behind them; k never exceeds Q_DEPTH because full blocks enqueue.
    always_comb begin
        int unsigned k;
        entry_t      e;
        k     = 0;
        e     = '0;
        q_nxt = q;
        for (int unsigned i = 0; i < N_FU; i++) begin
            k = 0;
            for (int unsigned j = 0; j < Q_DEPTH; j++) begin
                e = q[i][j];
                if ((j < 32'(cnt[i])) && !is_kill(recov, e.mask, fix) &&
                    !((j == 0) && win_vld && (32'(win_idx) == i))) begin
                    if (clr_en) e.mask = e.mask & ~fix;
                    q_nxt[i][k] = e;
                    k = k + 1;
                end
            end
            e.tag  = bus.fu_tag_i[i*TW +: TW];
            e.rob  = bus.fu_rob_idx_i[i*RW +: RW];
            e.mask = bus.fu_br_mask_i[i*MW +: MW];
            if (bus.fu_done_i[i] && !full[i] && !is_kill(recov, e.mask, fix)) begin
                if (clr_en) e.mask = e.mask & ~fix;
                if (k < Q_DEPTH) q_nxt[i][k] = e;
                k = k + 1;
            end
            cnt_nxt[i] = CW'(k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            for (int unsigned i = 0; i < N_FU; i++) begin
                cnt[i] <= '0;
                for (int unsigned j = 0; j < Q_DEPTH; j++) q[i][j] <= '0;
            end
        end else begin
            rr_ptr <= rr_nxt;
            cnt    <= cnt_nxt;
            q      <= q_nxt;
        end
    end

`ifdef CDB_ARB_DEBUG_EN
    always_comb begin
        dbg_q_cnt_o = '0;
        for (int unsigned i = 0; i < N_FU; i++) dbg_q_cnt_o[i*3 +: 3] = 3'(cnt[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       dbg_bcast_cnt_o <= '0;
        else if (win_vld) dbg_bcast_cnt_o <= dbg_bcast_cnt_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_cdb_arb.sv
// Randomized and directed bench for cdb_arb against a queue-based reference model.
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif

module tb_cdb_arb;
    localparam int N  = 4;
    localparam int QD = 2;
    localparam int TW = `PRF_IDX_W;
    localparam int RW = `ROB_IDX_W;
    localparam int MW = `BR_MASK_W;

    typedef struct {
        int tag;
        int rob;
        int mask;
    } ent_t;

    logic clk;
    logic rst_n;
    cdb_arb_if #(.N_FU(N)) bus ();

`ifdef CDB_ARB_DEBUG_EN
    logic [N*3-1:0] dbg_q_cnt;
    logic [31:0]    dbg_bcast_cnt;
`endif

    cdb_arb #(.N_FU(N), .Q_DEPTH(QD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CDB_ARB_DEBUG_EN
        ,
        .dbg_q_cnt_o     (dbg_q_cnt),
        .dbg_bcast_cnt_o (dbg_bcast_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_viol  = 0;

    ent_t mq [N][$];
    int   m_rr;
    int   m_win;

    logic [N-1:0] s_done;
    int s_tag [N];
    int s_rob [N];
    int s_mask[N];
    bit s_pc, s_rec;
    int s_fix;

    logic        obs_vld;
    int          obs_tag, obs_rob;
    logic [N-1:0] obs_full;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit mkill(input int m);
        return s_rec && ((m & s_fix) != 0);
    endfunction

    task automatic idle_stim();
        s_done = '0;
        s_pc   = 1'b0;
        s_rec  = 1'b0;
        s_fix  = 0;
        for (int f = 0; f < N; f++) begin
            s_tag[f] = 0; s_rob[f] = 0; s_mask[f] = 0;
        end
    endtask

    task automatic put(input int f, input int tag, input int rob, input int mask);
        s_done[f] = 1'b1;
        s_tag[f]  = tag;
        s_rob[f]  = rob;
        s_mask[f] = mask;
    endtask

    task automatic drive();
        for (int f = 0; f < N; f++) begin
            bus.fu_done_i[f]              = s_done[f];
            bus.fu_tag_i[f*TW +: TW]      = s_tag[f][TW-1:0];
            bus.fu_rob_idx_i[f*RW +: RW]  = s_rob[f][RW-1:0];
            bus.fu_br_mask_i[f*MW +: MW]  = s_mask[f][MW-1:0];
        end
        bus.br_pred_correct_i = s_pc;
        bus.br_recovery_i     = s_rec;
        bus.br_tag_fix_i      = s_fix[MW-1:0];
    endtask

    // Drive this cycle's inputs, then compare the combinational outputs with the model.
    task automatic tick_pre();
        int i;
        logic [N-1:0] exp_full;
        drive();
        #1;
        m_win = -1;
        for (int k = 0; k < N; k++) begin
            i = (m_rr + k) % N;
            if (m_win < 0 && mq[i].size() > 0 && !mkill(mq[i][0].mask)) m_win = i;
        end
        for (int f = 0; f < N; f++) exp_full[f] = (mq[f].size() == QD);
        obs_vld  = bus.cdb_vld_o;
        obs_tag  = 32'(bus.cdb_tag_o);
        obs_rob  = 32'(bus.cdb_rob_idx_o);
        obs_full = bus.fu_full_o;
        check("cdb_vld", 32'(obs_vld), 32'(m_win >= 0));
        check("cdb_tag", obs_tag, (m_win >= 0) ? mq[m_win][0].tag : 0);
        check("cdb_rob", obs_rob, (m_win >= 0) ? mq[m_win][0].rob : 0);
        check("fu_full", 32'(obs_full), 32'(exp_full));
        for (int f = 0; f < N; f++)
            if (s_done[f] && obs_full[f]) begin
                n_viol++;
                $display("[TB] note: FU%0d done while full at %0t (result dropped)", f, $time);
            end
    endtask

    task automatic tick_post();
        ent_t nq[$];
        ent_t e;
        @(posedge clk);
        for (int f = 0; f < N; f++) begin
            nq = {};
            for (int j = 0; j < mq[f].size(); j++) begin
                e = mq[f][j];
                if (mkill(e.mask) || (j == 0 && f == m_win)) continue;
                if (s_pc && !s_rec) e.mask = e.mask & ~s_fix;
                nq.push_back(e);
            end
            if (s_done[f] && mq[f].size() < QD && !mkill(s_mask[f])) begin
                e.tag  = s_tag[f];
                e.rob  = s_rob[f];
                e.mask = (s_pc && !s_rec) ? (s_mask[f] & ~s_fix) : s_mask[f];
                nq.push_back(e);
            end
            mq[f] = nq;
        end
        if (m_win >= 0) m_rr = (m_win + 1) % N;
        @(negedge clk);
    endtask

    task automatic tick();
        tick_pre();
        tick_post();
    endtask

    task automatic model_reset();
        for (int f = 0; f < N; f++) mq[f] = {};
        m_rr = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        idle_stim();
        drive();
        #2;
        check("rst_vld",  32'(bus.cdb_vld_o), 0);
        check("rst_tag",  32'(bus.cdb_tag_o), 0);
        check("rst_rob",  32'(bus.cdb_rob_idx_o), 0);
        check("rst_full", 32'(bus.fu_full_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single result: no same-cycle bypass, one broadcast cycle
        for (int c = 0; c < 5; c++) tick();
        put(1, 'h15, 3, 0);
        tick_pre();
        check("single_nobypass", 32'(obs_vld), 0);
        tick_post();
        idle_stim();
        tick_pre();
        check("single_vld", 32'(obs_vld), 1);
        check("single_tag", obs_tag, 'h15);
        check("single_rob", obs_rob, 3);
        tick_post();
        tick_pre();
        check("single_once", 32'(obs_vld), 0);
        tick_post();

        // contention with rr_ptr at 2
        for (int f = 0; f < N; f++) put(f, 'h20 + f, 8 + f, 0);
        tick();
        idle_stim();
        for (int c = 0; c < 4; c++) begin
            tick_pre();
            check("rr_order_tag", obs_tag, 'h20 + ((2 + c) % N));
            check("rr_order_rob", obs_rob, 8 + ((2 + c) % N));
            tick_post();
        end
        tick();

        // full queue: third FU0 result dropped
        for (int f = 0; f < N; f++) put(f, 'h30 + f, f, 0);
        tick();
        idle_stim(); put(0, 'h38, 4, 0);
        tick();
        idle_stim(); put(0, 'h3F, 5, 0);
        tick_pre();
        check("full_set", 32'(obs_full[0]), 1);
        tick_post();
        idle_stim();
        tick_pre();
        check("full_hold_on_deq", 32'(obs_full[0]), 1);
        check("full_head_tag", obs_tag, 'h30);
        tick_post();
        tick();
        tick_pre();
        check("full_second_tag", obs_tag, 'h38);
        tick_post();
        tick_pre();
        check("full_drained", 32'(obs_vld), 0);
        tick_post();
        check("drop_flag", n_viol, 1);

        // async reset mid-drain with three queued entries
        put(0, 'h10, 1, 0); put(1, 'h11, 2, 0); put(2, 'h12, 3, 0);
        tick();
        idle_stim(); put(0, 'h18, 4, 0);
        tick();
        idle_stim();
        tick_pre();
        check("pre_rst_full", 32'(obs_full[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_vld",  32'(bus.cdb_vld_o), 0);
        check("mid_rst_full", 32'(bus.fu_full_o), 0);
        check("mid_rst_tag",  32'(bus.cdb_tag_o), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick_pre();
        check("post_rst_vld", 32'(obs_vld), 0);
        tick_post();
        tick();

        // squash: head with mask 0010 killed, 0100 entry broadcasts next
        put(1, 'h21, 1, 0);
        tick();
        idle_stim(); put(0, 'h2A, 10, 'b0010); put(2, 'h22, 2, 0); put(3, 'h23, 3, 0);
        tick();
        idle_stim(); put(0, 'h2B, 11, 'b0100);
        tick();
        idle_stim(); s_rec = 1'b1; s_fix = 'b0010;
        tick_pre();
        check("squash_other_tag", obs_tag, 'h23);
        tick_post();
        idle_stim();
        tick_pre();
        check("squash_survivor_tag", obs_tag, 'h2B);
        check("squash_survivor_rob", obs_rob, 11);
        tick_post();
        tick_pre();
        check("squash_no_killed", 32'(obs_vld), 0);
        tick_post();

        // correct prediction clears the bit, later recovery on it does not kill
        put(0, 'h2C, 12, 'b0110); put(1, 'h2D, 13, 0);
        tick();
        idle_stim(); s_pc = 1'b1; s_fix = 'b0010;
        tick();
        idle_stim(); s_rec = 1'b1; s_fix = 'b0010;
        tick_pre();
        check("clr_survive_tag", obs_tag, 'h2C);
        tick_post();
        idle_stim();
        tick();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            idle_stim();
            for (int f = 0; f < N; f++)
                if ($urandom_range(0, 1) == 1 && (mq[f].size() < QD || $urandom_range(0, 15) == 0))
                    put(f, int'($urandom_range(0, (1 << TW) - 1)), int'($urandom_range(0, (1 << RW) - 1)),
                        ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, (1 << MW) - 1)) : 0);
            if ($urandom_range(0, 7) == 0) s_rec = 1'b1;
            if ($urandom_range(0, 7) == 0) s_pc = 1'b1;
            s_fix = 1 << $urandom_range(0, MW - 1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_arb.md
# cdb_arb

Common Data Bus arbiter and broadcaster: the producer side of the tag-wakeup interface consumed by every reservation-station entry and the ROB. It collects completed results from N_FU functional units into small per-FU completion queues, picks one per cycle round-robin, and drives `cdb_vld_o`/`cdb_tag_o`/`cdb_rob_idx_o`. Queued results are squashed on branch misprediction and their branch masks are cleared on correct prediction, matching the RS entry recovery semantics.

## Interface
Parameters:
- N_FU, 4, number of functional-unit completion ports (2..8)
- Q_DEPTH, 2, entries per FU completion queue (1..4)

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  Reset is asynchronous and active-low.
- fu_done_i  in  N_FU  per-FU result valid this cycle
- fu_tag_i  in  N_FU*`PRF_IDX_W  per-FU destination PRF tag, FU i at slice i
- fu_rob_idx_i  in  N_FU*`ROB_IDX_W  per-FU ROB index
- fu_br_mask_i  in  N_FU*`BR_MASK_W  per-FU branch mask
- fu_full_o  out  N_FU  queue i full; FU i must not assert fu_done_i[i]
- br_pred_correct_i  in  1  branch resolved correct
- br_recovery_i  in  1  branch mispredicted
- br_tag_fix_i  in  `BR_MASK_W  one-hot tag of the resolved branch
- cdb_vld_o  out  1  broadcast valid
- cdb_tag_o  out  `PRF_IDX_W  broadcast PRF tag
- cdb_rob_idx_o  out  `ROB_IDX_W  broadcast ROB index

## Operation
- Per-FU FIFO of Q_DEPTH entries {tag, rob_idx, br_mask}, head-ordered by arrival. Count per queue 0..Q_DEPTH.
- Enqueue: fu_done_i[i] && !fu_full_o[i] && !kill(incoming) → write at tail. Done while full: ignored, result dropped (protocol violation; bench flags).
- kill(m) = br_recovery_i && (m & br_tag_fix_i) != 0. Applies to every stored entry and every incoming result in the same cycle; killed entries are removed, survivors compact toward head keeping order.
- br_pred_correct_i (and not br_recovery_i): every stored and incoming mask gets `& ~br_tag_fix_i`. If both asserted, recovery wins and no clear occurs.
- Candidate i = queue i non-empty and head not killed this cycle.
- Arbitration: search from rr_ptr upward mod N_FU; first candidate wins. Winner head dequeued at edge; rr_ptr ← winner+1 mod N_FU. No winner: rr_ptr unchanged.
- cdb_vld_o = any candidate; cdb_tag_o/cdb_rob_idx_o = winner head fields; both 0 when cdb_vld_o = 0. Combinational from queue state + recovery inputs, so a head killed this cycle is never broadcast.
- fu_full_o[i] = (count_i == Q_DEPTH), from registered count only; a same-cycle dequeue does not deassert it.
- Tag 0 is a legal tag and broadcast normally.

## Timing
- Reset (rst_n low, async): all queues empty, rr_ptr = 0, fu_full_o = 0, cdb_vld_o = 0, cdb_tag_o = 0, cdb_rob_idx_o = 0.
- Latency: fu_done_i in cycle N → earliest broadcast in cycle N+1 (no same-cycle bypass).
- One broadcast per cycle max; a queue drains at most one entry per cycle.
- Starvation bound: a non-empty head broadcasts within N_FU cycles absent squash.
- Reset mid-operation discards all queued results; no broadcast in the first cycle after release.

## Configuration
- `CDB_ARB_DEBUG_EN`: when defined, adds outputs `dbg_q_cnt_o` (N_FU*3 bits, per-queue count) and `dbg_bcast_cnt_o` (32-bit broadcast counter, +1 per cycle with cdb_vld_o, reset 0, wraps). When undefined these ports and counters do not exist; functional behaviour identical.

## Test plan
- Single result: FU1 done tag=0x15 rob=3 mask=0 at cycle 5, others idle → cdb_vld_o=1, tag 0x15, rob 3 in cycle 6 only.
- Contention: all 4 FUs done same cycle, rr_ptr=2 → broadcasts in order FU2, FU3, FU0, FU1 on four consecutive cycles.
- Full: FU0 done 3 consecutive cycles with arbiter busy on others, Q_DEPTH=2 → fu_full_o[0]=1 after second enqueue; third result dropped; flag raised.
- Squash: queued masks 0b0010 and 0b0100 on FU0, recovery with fix=0b0010 → first entry removed, 0b0100 entry becomes head and broadcasts next cycle; killed tag never appears on CDB.
- Correct prediction: queued mask 0b0110, pred_correct fix=0b0010, then recovery fix=0b0010 → entry survives (mask now 0b0100) and broadcasts.
- Async reset asserted mid-drain with 3 entries queued → cdb_vld_o and fu_full_o go 0 immediately; after release nothing is broadcast.
